// File: rtl/k12a_mem_arbiter_pkg.sv
// k12a_mem_arbiter_pkg: shared types for the K12A memory port arbiter.
// Memory modes, arbiter states and bus owners.
package k12a_mem_arbiter_pkg;

  typedef enum logic {
    MEM_MODE_READ  = 1'b0,
    MEM_MODE_WRITE = 1'b1
  } mem_mode_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_DMA  = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OWNER_CPU = 1'b0,
    ARB_OWNER_DMA = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/k12a_mem_arbiter_if.sv
// k12a_mem_arbiter_if: CPU, DMA and memory signals around the arbiter.
// dma_lock exists only when K12A_DMA_LOCK_EN is defined.
interface k12a_mem_arbiter_if;
  import k12a_mem_arbiter_pkg::*;

  logic       cpu_req;
  mem_mode_t  cpu_mode;
  logic [15:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;
  logic       cpu_ack;

  logic       dma_req;
  mem_mode_t  dma_mode;
  logic [15:0] dma_addr;
  logic [7:0] dma_wdata;
  logic [7:0] dma_rdata;
  logic       dma_ack;
`ifdef K12A_DMA_LOCK_EN
  logic       dma_lock;
`endif

  logic       mem_enable;
  mem_mode_t  mem_mode;
  logic [15:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_mode, cpu_addr, cpu_wdata,
    input  dma_req, dma_mode, dma_addr, dma_wdata,
    input  mem_rdata,
`ifdef K12A_DMA_LOCK_EN
    input  dma_lock,
`endif
    output cpu_rdata, cpu_stall, cpu_ack,
    output dma_rdata, dma_ack,
    output mem_enable, mem_mode, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_mode, cpu_addr, cpu_wdata,
    output dma_req, dma_mode, dma_addr, dma_wdata,
    output mem_rdata,
`ifdef K12A_DMA_LOCK_EN
    output dma_lock,
`endif
    input  cpu_rdata, cpu_stall, cpu_ack,
    input  dma_rdata, dma_ack,
    input  mem_enable, mem_mode, mem_addr, mem_wdata
  );

endinterface

// File: rtl/k12a_wait_counter.sv
// k12a_wait_counter: 4-bit loadable down-counter for memory wait states.
// done flags the last cycle of an access (count == 1).
module k12a_wait_counter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] value,
  output logic       done
);

  logic [3:0] cnt_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign done = (cnt_q == 4'd1);

endmodule

// File: rtl/k12a_mem_arbiter.sv
// k12a_mem_arbiter: shares one memory port between CPU and DMA with wait states.
// K12A_DMA_LOCK_EN adds dma_lock, letting DMA keep the bus across accesses.
module k12a_mem_arbiter
  import k12a_mem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_STATES    = 1,
  parameter int unsigned MAX_CPU_STREAK = 4
) (
  input  logic clock,
  input  logic reset_n,
  k12a_mem_arbiter_if.slave bus
);

  localparam logic [3:0] WS  = 4'(WAIT_STATES);
  localparam logic [3:0] MAX = 4'(MAX_CPU_STREAK);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d, sel;
  logic [3:0] streak_q, streak_d;
  logic       en, load, done, lock;
  logic       cpu_win, dma_win;
  logic       cpu_ack, dma_ack;

`ifdef K12A_DMA_LOCK_EN
  assign lock = (owner_q == ARB_OWNER_DMA) & bus.dma_lock;
`else
  assign lock = 1'b0;
`endif

  k12a_wait_counter u_wait (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load),
    .value   (WS),
    .done    (done)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= ARB_OWNER_CPU;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    sel      = owner_q;
    en       = 1'b0;
    load     = 1'b0;
    cpu_ack  = 1'b0;
    dma_ack  = 1'b0;
    cpu_win  = 1'b0;
    dma_win  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        dma_win = reset_n & bus.dma_req &
                  (lock | ~bus.cpu_req | (streak_q == MAX));
        cpu_win = reset_n & bus.cpu_req & ~dma_win & ~lock;
        if (dma_win | cpu_win) begin
          sel     = dma_win ? ARB_OWNER_DMA : ARB_OWNER_CPU;
          owner_d = sel;
          en      = 1'b1;
          if (WS == 4'd0) begin
            cpu_ack = cpu_win;
            dma_ack = dma_win;
          end else begin
            load    = 1'b1;
            state_d = dma_win ? ARB_DMA : ARB_CPU;
          end
        end
      end
      ARB_CPU: begin
        sel = ARB_OWNER_CPU;
        en  = 1'b1;
        if (done) begin
          cpu_ack = reset_n;
          state_d = ARB_IDLE;
        end
      end
      ARB_DMA: begin
        sel = ARB_OWNER_DMA;
        en  = 1'b1;
        if (done) begin
          dma_ack = reset_n;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // Streak only counts CPU wins taken while DMA is kept waiting.
    if (~bus.dma_req | dma_win | lock) begin
      streak_d = '0;
    end else if (cpu_win & (streak_q != MAX)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_comb begin
    bus.mem_mode  = MEM_MODE_READ;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (en) begin
      if (sel == ARB_OWNER_DMA) begin
        bus.mem_mode  = bus.dma_mode;
        bus.mem_addr  = bus.dma_addr;
        bus.mem_wdata = bus.dma_wdata;
      end else begin
        bus.mem_mode  = bus.cpu_mode;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
      end
    end
  end

  assign bus.mem_enable = en;
  assign bus.cpu_ack    = cpu_ack;
  assign bus.dma_ack    = dma_ack;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_ack;
  assign bus.cpu_rdata  = (en & (sel == ARB_OWNER_CPU)) ? bus.mem_rdata : 8'h00;
  assign bus.dma_rdata  = dma_ack ? bus.mem_rdata : 8'h00;

endmodule

// File: tb/tb_k12a_mem_arbiter.sv
// tb_k12a_mem_arbiter: vector table and sequences against three arbiters
// built with WAIT_STATES 0, 1 and 2; checks K12A_DMA_LOCK_EN when defined.
module tb_k12a_mem_arbiter;
  import k12a_mem_arbiter_pkg::*;

  typedef struct packed {
    logic        cpu_req;
    mem_mode_t   cpu_mode;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        dma_req;
    mem_mode_t   dma_mode;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic [7:0]  mem_rdata;
  } in_t;

  typedef struct packed {
    logic        mem_enable;
    mem_mode_t   mem_mode;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_ack;
    logic        cpu_stall;
    logic [7:0]  cpu_rdata;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  localparam mem_mode_t R = MEM_MODE_READ;
  localparam mem_mode_t W = MEM_MODE_WRITE;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic clk;
  logic rst_n;
  in_t  din [3];
  out_t dout [3];
  vec_t tbl [$];
  vec_t exp_q [$];
  int   checks;
  int   failures;
`ifdef K12A_DMA_LOCK_EN
  logic lock0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    k12a_mem_arbiter_if b ();

    k12a_mem_arbiter #(
      .WAIT_STATES    (g),
      .MAX_CPU_STREAK (4)
    ) u_dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (b)
    );

    assign b.cpu_req   = din[g].cpu_req;
    assign b.cpu_mode  = din[g].cpu_mode;
    assign b.cpu_addr  = din[g].cpu_addr;
    assign b.cpu_wdata = din[g].cpu_wdata;
    assign b.dma_req   = din[g].dma_req;
    assign b.dma_mode  = din[g].dma_mode;
    assign b.dma_addr  = din[g].dma_addr;
    assign b.dma_wdata = din[g].dma_wdata;
    assign b.mem_rdata = din[g].mem_rdata;
`ifdef K12A_DMA_LOCK_EN
    assign b.dma_lock  = (g == 0) ? lock0 : 1'b0;
`endif
    assign dout[g] = {b.mem_enable, b.mem_mode, b.mem_addr,
                      b.mem_wdata, b.cpu_ack, b.cpu_stall,
                      b.cpu_rdata, b.dma_ack, b.dma_rdata};
  end

  function automatic in_t vi(
    logic cr, mem_mode_t cm, logic [15:0] ca, logic [7:0] cw,
    logic dr, mem_mode_t dm, logic [15:0] da, logic [7:0] dw,
    logic [7:0] mr);
    return {cr, cm, ca, cw, dr, dm, da, dw, mr};
  endfunction

  function automatic out_t vo(
    logic en, mem_mode_t mm, logic [15:0] ma, logic [7:0] mw,
    logic ca, logic cs, logic [7:0] crd, logic da, logic [7:0] drd);
    return {en, mm, ma, mw, ca, cs, crd, da, drd};
  endfunction

  function automatic vec_t mk(string n, in_t i, out_t o);
    vec_t v;
    v.name = n;
    v.i    = i;
    v.o    = o;
    return v;
  endfunction

  task automatic chk(string name, out_t act, out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Drive after the edge, score the popped expectation on the falling edge.
  task automatic step(int g, vec_t v);
    vec_t e;
    din[g] = v.i;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk(e.name, dout[g], e.o);
    @(posedge clk);
    #1;
  endtask

  task automatic run(int g);
    for (int k = 0; k < tbl.size(); k++) step(g, tbl[k]);
    tbl.delete();
    din[g] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    in_t  both, ci, di;
    out_t oc, od, oz;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int g = 0; g < 3; g++) din[g] = '0;
`ifdef K12A_DMA_LOCK_EN
    lock0 = 1'b0;
`endif
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) step(g, mk("reset", '0, '0));
    rst_n = 1'b1;

    oz   = '0;
    both = vi(T, R, 16'h1000, 8'h01, T, W, 16'h2000, 8'h02, 8'h33);
    oc   = vo(T, R, 16'h1000, 8'h01, T, F, 8'h33, F, 8'h00);
    od   = vo(T, W, 16'h2000, 8'h02, F, T, 8'h00, T, 8'h33);

    // WAIT_STATES=0: single-cycle accesses and CPU streak limiting.
    tbl.push_back(mk("ws0_cpu_rd",
      vi(T, R, 16'h1234, 8'h00, F, R, 16'h0000, 8'h00, 8'hA5),
      vo(T, R, 16'h1234, 8'h00, T, F, 8'hA5, F, 8'h00)));
    tbl.push_back(mk("ws0_cpu_wr",
      vi(T, W, 16'h8010, 8'h3C, F, R, 16'h0000, 8'h00, 8'h77),
      vo(T, W, 16'h8010, 8'h3C, T, F, 8'h77, F, 8'h00)));
    tbl.push_back(mk("ws0_idle_bus",
      vi(F, W, 16'hBEEF, 8'hEE, F, W, 16'hCAFE, 8'hDD, 8'h5A), oz));
    tbl.push_back(mk("ws0_dma_wr",
      vi(F, R, 16'h0000, 8'h00, T, W, 16'h0200, 8'h99, 8'h11),
      vo(T, W, 16'h0200, 8'h99, F, F, 8'h00, T, 8'h11)));
    tbl.push_back(mk("ws0_dma_rd",
      vi(F, R, 16'h0000, 8'h00, T, R, 16'h0300, 8'h44, 8'h22),
      vo(T, R, 16'h0300, 8'h44, F, F, 8'h00, T, 8'h22)));
    for (int k = 1; k <= 4; k++) tbl.push_back(mk($sformatf("streak_cpu%0d", k), both, oc));
    tbl.push_back(mk("streak_dma", both, od));
    tbl.push_back(mk("streak_cpu_after", both, oc));
    tbl.push_back(mk("streak_dma_drop",
      vi(T, R, 16'h1000, 8'h01, F, W, 16'h2000, 8'h02, 8'h33), oc));
    for (int k = 1; k <= 4; k++) tbl.push_back(mk($sformatf("restreak_cpu%0d", k), both, oc));
    tbl.push_back(mk("restreak_dma", both, od));
    run(0);

    // WAIT_STATES=2: three-cycle CPU write.
    ci = vi(T, W, 16'h8010, 8'h3C, F, R, 16'h0000, 8'h00, 8'h6E);
    tbl.push_back(mk("ws2_wr_c1", ci, vo(T, W, 16'h8010, 8'h3C, F, T, 8'h6E, F, 8'h00)));
    tbl.push_back(mk("ws2_wr_c2", ci, vo(T, W, 16'h8010, 8'h3C, F, T, 8'h6E, F, 8'h00)));
    tbl.push_back(mk("ws2_wr_c3", ci, vo(T, W, 16'h8010, 8'h3C, T, F, 8'h6E, F, 8'h00)));
    tbl.push_back(mk("ws2_wr_done", vi(F, R, 16'h0, 8'h0, F, R, 16'h0, 8'h0, 8'h6E), oz));
    run(2);

    // WAIT_STATES=1: DMA read, CPU waits through the DMA ack cycle.
    di = vi(F, R, 16'h0000, 8'h00, T, R, 16'h0100, 8'h00, 8'hC3);
    tbl.push_back(mk("ws1_dma_c1", di, vo(T, R, 16'h0100, 8'h00, F, F, 8'h00, F, 8'h00)));
    tbl.push_back(mk("ws1_dma_ack",
      vi(T, R, 16'h4444, 8'h00, T, R, 16'h0100, 8'h00, 8'hC3),
      vo(T, R, 16'h0100, 8'h00, F, T, 8'h00, T, 8'hC3)));
    ci = vi(T, R, 16'h4444, 8'h00, F, R, 16'h0000, 8'h00, 8'hC3);
    tbl.push_back(mk("ws1_cpu_c1", ci, vo(T, R, 16'h4444, 8'h00, F, T, 8'hC3, F, 8'h00)));
    tbl.push_back(mk("ws1_cpu_ack", ci, vo(T, R, 16'h4444, 8'h00, T, F, 8'hC3, F, 8'h00)));
    tbl.push_back(mk("ws1_idle", '0, oz));
    run(1);

    // WAIT_STATES=2: reset in cycle 2 aborts the access.
    ci = vi(T, R, 16'h5555, 8'h00, F, R, 16'h0000, 8'h00, 8'h10);
    oc = vo(T, R, 16'h5555, 8'h00, F, T, 8'h10, F, 8'h00);
    tbl.push_back(mk("rst_acc_c1", ci, oc));
    run(2);
    rst_n = 1'b0;
    tbl.push_back(mk("rst_acc_c2", ci, oc));
    run(2);
    rst_n = 1'b1;
    tbl.push_back(mk("rst_aborted", vi(F, R, 16'h5555, 8'h00, F, R, 16'h0, 8'h0, 8'h10), oz));
    tbl.push_back(mk("rst_new_c1", ci, oc));
    tbl.push_back(mk("rst_new_c2", ci, oc));
    tbl.push_back(mk("rst_new_ack", ci, vo(T, R, 16'h5555, 8'h00, T, F, 8'h10, F, 8'h00)));
    tbl.push_back(mk("rst_new_idle", '0, oz));
    run(2);

`ifdef K12A_DMA_LOCK_EN
    lock0 = 1'b1;
    tbl.push_back(mk("lock_dma1",
      vi(F, R, 16'h1111, 8'h00, T, R, 16'h0400, 8'h00, 8'hAA),
      vo(T, R, 16'h0400, 8'h00, F, F, 8'h00, T, 8'hAA)));
    tbl.push_back(mk("lock_dma2",
      vi(T, R, 16'h1111, 8'h00, T, R, 16'h0401, 8'h00, 8'hAA),
      vo(T, R, 16'h0401, 8'h00, F, T, 8'h00, T, 8'hAA)));
    tbl.push_back(mk("lock_cpu_held",
      vi(T, R, 16'h1111, 8'h00, F, R, 16'h0000, 8'h00, 8'hAA),
      vo(F, R, 16'h0000, 8'h00, F, T, 8'h00, F, 8'h00)));
    run(0);
    lock0 = 1'b0;
    tbl.push_back(mk("lock_released",
      vi(T, R, 16'h1111, 8'h00, F, R, 16'h0000, 8'h00, 8'hAA),
      vo(T, R, 16'h1111, 8'h00, T, F, 8'hAA, F, 8'h00)));
    run(0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
